// File: rtl/dp_types_pkg.sv
// Shared datapath types for the fetch stage: PC-source select, fetch FSM
// states and the reset PC.
package dp_types_pkg;

  typedef enum logic [2:0] {
    PCSRC_NPC = 3'd0,
    PCSRC_JAL = 3'd1,
    PCSRC_REG = 3'd2,
    PCSRC_BEQ = 3'd3,
    PCSRC_BNE = 3'd4
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  // Sequential PC increment; wraps silently at the top of the address space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_target.sv
// Combinational redirect-target calculation for jumps, register jumps and
// conditional branches.
module pc_target
  import dp_types_pkg::*;
(
  input  pcsrc_t      pcsrc,
  input  logic [31:0] npc,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  logic [31:0] rdat,
  output logic [31:0] target
);

  logic [31:0] branch_offset;

  // Sign-extended word offset for branches.
  always_comb begin
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  end

  // Select the target address for the decoded PC source.
  always_comb begin
    target = npc;
    case (pcsrc)
      PCSRC_JAL: target = {npc[31:28], jaddr, 2'b00};
      PCSRC_REG: target = rdat;
      PCSRC_BEQ,
      PCSRC_BNE: target = npc + branch_offset;
      default:   target = npc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, I-cache request, redirect/squash
// handling and the IF/ID pipeline latch.
module fetch_stage
  import dp_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        id_valid,
  input  pcsrc_t      id_pcsrc,
  input  logic        id_zero,
  input  logic [31:0] id_npc,
  input  logic [15:0] id_imm,
  input  logic [25:0] id_jaddr,
  input  logic [31:0] id_rdat,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  redirect_pc, redirect_pc_next;
  logic [31:0]  ifid_instr_next, ifid_npc_next;
  logic         ifid_valid_next;
  logic [31:0]  target;
  logic         redirect;

  pc_target u_pc_target (
    .pcsrc  (id_pcsrc),
    .npc    (id_npc),
    .imm    (id_imm),
    .jaddr  (id_jaddr),
    .rdat   (id_rdat),
    .target (target)
  );

  // Decide whether the instruction in decode redirects fetch this cycle.
  always_comb begin
    redirect = id_valid & ~stall &
               ((id_pcsrc == PCSRC_JAL) |
                (id_pcsrc == PCSRC_REG) |
                ((id_pcsrc == PCSRC_BEQ) &  id_zero) |
                ((id_pcsrc == PCSRC_BNE) & ~id_zero));
  end

  // Next-state, PC and IF/ID latch logic; priority halt > redirect > stall > ihit.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    redirect_pc_next = redirect_pc;
    ifid_instr_next  = ifid_instr;
    ifid_npc_next    = ifid_npc;
    ifid_valid_next  = ifid_valid;
    imemREN          = (state != HALTED);
    imemaddr         = pc;

    case (state)
      FETCH: begin
        if (halt) begin
          state_next      = HALTED;
          ifid_valid_next = 1'b0;
        end else if (redirect) begin
          ifid_valid_next = 1'b0;
          if (ihit) begin
            pc_next = target;
          end else begin
            // Keep the miss address stable; apply the target once it returns.
            redirect_pc_next = target;
            state_next       = SQUASH;
          end
        end else if (stall) begin
          // Hold everything; the cache re-presents the hit next cycle.
        end else if (ihit) begin
          ifid_instr_next = iload;
          ifid_npc_next   = pc_plus4(pc);
          ifid_valid_next = 1'b1;
          pc_next         = pc_plus4(pc);
        end else begin
          ifid_valid_next = 1'b0;
        end
      end

      SQUASH: begin
        if (halt) begin
          state_next      = HALTED;
          ifid_valid_next = 1'b0;
        end else if (stall) begin
          // Hold.
        end else if (ihit) begin
          pc_next         = redirect_pc;
          ifid_valid_next = 1'b0;
          state_next      = FETCH;
        end else begin
          ifid_valid_next = 1'b0;
        end
      end

      HALTED: begin
        ifid_valid_next = 1'b0;
      end

      default: begin
        state_next      = FETCH;
        ifid_valid_next = 1'b0;
      end
    endcase
  end

  // Registered state, PC and IF/ID latch with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      redirect_pc <= '0;
      ifid_instr  <= '0;
      ifid_npc    <= '0;
      ifid_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_pc_next;
      ifid_instr  <= ifid_instr_next;
      ifid_npc    <= ifid_npc_next;
      ifid_valid  <= ifid_valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import dp_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        id_valid;
  pcsrc_t      id_pcsrc;
  logic        id_zero;
  logic [31:0] id_npc;
  logic [15:0] id_imm;
  logic [25:0] id_jaddr;
  logic [31:0] id_rdat;
  logic        stall;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state.
  logic [31:0] m_pc, m_rpc, m_instr, m_npc;
  logic        m_valid, m_pending, m_halted;

  fetch_stage dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .iload      (iload),
    .id_valid   (id_valid),
    .id_pcsrc   (id_pcsrc),
    .id_zero    (id_zero),
    .id_npc     (id_npc),
    .id_imm     (id_imm),
    .id_jaddr   (id_jaddr),
    .id_rdat    (id_rdat),
    .stall      (stall),
    .halt       (halt),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_target();
    case (id_pcsrc)
      PCSRC_JAL: return (id_npc & 32'hF000_0000) + ({6'd0, id_jaddr} * 32'd4);
      PCSRC_REG: return id_rdat;
      default:   return id_npc + 32'($signed(id_imm) * 4);
    endcase
  endfunction

  function automatic bit model_taken();
    if (!id_valid || stall) return 1'b0;
    case (id_pcsrc)
      PCSRC_JAL, PCSRC_REG: return 1'b1;
      PCSRC_BEQ:            return id_zero;
      PCSRC_BNE:            return !id_zero;
      default:              return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (RST) begin
      m_pc = 32'h0; m_rpc = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
      m_valid = 1'b0; m_pending = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (halt) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (!m_pending && model_taken()) begin
      m_valid = 1'b0;
      if (ihit) m_pc = model_target();
      else begin
        m_rpc     = model_target();
        m_pending = 1'b1;
      end
    end else if (stall) begin
      // hold
    end else if (m_pending) begin
      m_valid = 1'b0;
      if (ihit) begin
        m_pc      = m_rpc;
        m_pending = 1'b0;
      end
    end else if (ihit) begin
      m_instr = iload;
      m_npc   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check("imemaddr",   imemaddr,          m_pc);
    check("imemREN",    {31'd0, imemREN},  {31'd0, !m_halted});
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("ifid_npc",   ifid_npc,          m_npc);
    check("ifid_instr", ifid_instr,        m_instr);
  endtask

  task automatic quiet_inputs();
    RST = 1'b0; ihit = 1'b0; iload = 32'h0; id_valid = 1'b0;
    id_pcsrc = PCSRC_NPC; id_zero = 1'b0; id_npc = 32'h0; id_imm = 16'h0;
    id_jaddr = 26'h0; id_rdat = 32'h0; stall = 1'b0; halt = 1'b0;
  endtask

  initial begin
    quiet_inputs();

    // Reset, then a hit every cycle.
    RST = 1'b1;
    tick();
    check("rst_addr",  imemaddr, 32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_ren",   {31'd0, imemREN}, 32'd1);
    RST = 1'b0; ihit = 1'b1; iload = 32'h2001_0005;
    tick();
    check("seq_addr4",  imemaddr, 32'h4);
    check("seq_npc4",   ifid_npc, 32'h4);
    check("seq_valid1", {31'd0, ifid_valid}, 32'd1);
    check("seq_instr",  ifid_instr, 32'h2001_0005);
    tick();
    check("seq_addr8",  imemaddr, 32'h8);

    // Taken BEQ with the fetch hitting: immediate redirect.
    id_valid = 1'b1; id_pcsrc = PCSRC_BEQ; id_zero = 1'b1;
    id_npc = 32'h40; id_imm = 16'hFFFE;
    tick();
    check("beq_addr",  imemaddr, 32'h38);
    check("beq_valid", {31'd0, ifid_valid}, 32'd0);
    id_valid = 1'b0;
    tick();
    check("beq_after", imemaddr, 32'h3C);

    // Register jump resolved against a miss: squash until the miss returns.
    id_valid = 1'b1; id_pcsrc = PCSRC_REG; id_rdat = 32'h100; ihit = 1'b0;
    tick();
    check("sq_hold0", imemaddr, 32'h3C);
    id_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("sq_hold", imemaddr, 32'h3C);
      check("sq_valid", {31'd0, ifid_valid}, 32'd0);
    end
    ihit = 1'b1; iload = 32'hDEAD_BEEF;
    tick();
    check("sq_target", imemaddr, 32'h100);
    check("sq_discard", {31'd0, ifid_valid}, 32'd0);
    iload = 32'h1234_5678;
    tick();
    check("sq_resume_npc", ifid_npc, 32'h104);

    // Stall with a taken BNE present: nothing moves.
    stall = 1'b1; id_valid = 1'b1; id_pcsrc = PCSRC_BNE; id_zero = 1'b0;
    id_npc = 32'h500; id_imm = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_addr",  imemaddr, 32'h104);
      check("stall_npc",   ifid_npc, 32'h104);
      check("stall_valid", {31'd0, ifid_valid}, 32'd1);
    end
    stall = 1'b0; id_valid = 1'b0;

    // PC wrap at the top of the address space.
    id_valid = 1'b1; id_pcsrc = PCSRC_REG; id_rdat = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre", imemaddr, 32'hFFFF_FFFC);
    id_valid = 1'b0;
    tick();
    check("wrap_npc",  ifid_npc, 32'h0);
    check("wrap_addr", imemaddr, 32'h0);
    tick();

    // Halt freezes fetch until reset.
    halt = 1'b1;
    tick();
    check("halt_ren",   {31'd0, imemREN}, 32'd0);
    check("halt_valid", {31'd0, ifid_valid}, 32'd0);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_frozen", imemaddr, 32'h4);
    end
    RST = 1'b1;
    tick();
    check("halt_rst_addr", imemaddr, 32'h0);
    check("halt_rst_ren",  {31'd0, imemREN}, 32'd1);
    RST = 1'b0;

    // Reset during a pending squash drops the redirect.
    ihit = 1'b0; id_valid = 1'b1; id_pcsrc = PCSRC_JAL;
    id_npc = 32'h3000_0000; id_jaddr = 26'h80;
    tick();
    id_valid = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0; ihit = 1'b1;
    tick();
    check("sq_rst_addr", imemaddr, 32'h4);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      RST      = ($urandom_range(0, 99) < (m_halted ? 20 : 2));
      halt     = ($urandom_range(0, 99) < 2);
      ihit     = ($urandom_range(0, 99) < 60);
      iload    = $urandom;
      stall    = ($urandom_range(0, 99) < 15);
      id_valid = ($urandom_range(0, 99) < 40);
      id_pcsrc = pcsrc_t'($urandom_range(0, 4));
      id_zero  = $urandom_range(0, 1) == 1;
      id_npc   = $urandom;
      id_imm   = 16'($urandom);
      id_jaddr = 26'($urandom);
      id_rdat  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports CLK in 1 (sole clock, rising edge) and RST in 1 (synchronous, active-high reset).
REQ-002 SHALL have imemREN out 1 and imemaddr out 32: instruction-cache read request and word address.
REQ-003 SHALL have ihit in 1 and iload in 32: cache hit strobe and instruction word, valid together.
REQ-004 SHALL have id_valid in 1, id_pcsrc in pcsrc_t and id_zero in 1: decode-stage valid, PC-source select, ALU zero flag.
REQ-005 SHALL have id_npc in 32, id_imm in 16, id_jaddr in 26 and id_rdat in 32: decode-stage PC+4, immediate, jump field, rs value.
REQ-006 SHALL have stall in 1 (hazard hold) and halt in 1 (halt decoded).
REQ-007 SHALL have ifid_instr out 32, ifid_npc out 32 and ifid_valid out 1: the IF/ID latch.

Function
REQ-008 SHALL hold a 32-bit PC register; imemaddr = PC at all times.
REQ-009 SHALL implement FSM states FETCH, SQUASH, HALTED; imemREN = 1 in FETCH and SQUASH, 0 in HALTED.
REQ-010 SHALL compute redirect = id_valid & !stall & (pcsrc==PCSRC_JAL | pcsrc==PCSRC_REG | (PCSRC_BEQ & id_zero) | (PCSRC_BNE & !id_zero)).
REQ-011 SHALL compute target: JAL -> {id_npc[31:28], id_jaddr, 2'b00}; REG -> id_rdat; BEQ/BNE -> id_npc + (sign-extended id_imm << 2), mod 2^32.
REQ-012 SHALL apply per-cycle priority: RST > halt > redirect > stall > ihit.
REQ-013 halt in FETCH or SQUASH SHALL go to HALTED, clear ifid_valid, freeze PC; only RST leaves HALTED.
REQ-014 FETCH, redirect, ihit=1: PC <= target, ifid_valid <= 0, fetched word discarded, stay FETCH.
REQ-015 FETCH, redirect, ihit=0: latch target into redirect_pc, keep PC (address stable for the outstanding miss), ifid_valid <= 0, go SQUASH.
REQ-016 SQUASH, ihit=0: hold PC and redirect_pc, ifid_valid <= 0; further redirects ignored.
REQ-017 SQUASH, ihit=1: discard iload, PC <= redirect_pc, ifid_valid <= 0, go FETCH.
REQ-018 stall=1, no halt: PC, ifid_instr, ifid_npc and ifid_valid SHALL hold; ihit ignored (the cache re-hits next cycle).
REQ-019 FETCH, no redirect/stall, ihit=1: ifid_instr <= iload, ifid_npc <= PC+4, ifid_valid <= 1, PC <= PC+4.
REQ-020 FETCH, no redirect/stall, ihit=0: ifid_valid <= 0 (bubble), PC held.
REQ-021 PC+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without flagging.
REQ-022 Latency: an instruction hit at cycle N SHALL appear on ifid_* after edge N+1; a redirect SHALL drive imemaddr=target in the cycle after the hit that resolves it.

Reset
REQ-023 RST SHALL, at the next rising edge, set PC = PC_INIT (32'h0), redirect_pc = 0, state = FETCH, ifid_instr = 0, ifid_npc = 0, ifid_valid = 0.
REQ-024 RST in any state, including SQUASH with a miss outstanding, SHALL discard the pending redirect; imemaddr = 0 and imemREN = 1 the cycle after.

Structure
REQ-025 fetch_state_t and PC_INIT SHALL live in dp_types_pkg; pcsrc_t SHALL be reused from that package unchanged.
REQ-026 Target arithmetic (REQ-011) SHALL be a combinational sub-module pc_target; the FSM and latches SHALL stay in fetch_stage.

Verification
REQ-027 RST, then ihit=1 every cycle with iload=0x20010005 -> imemaddr 0,4,8,...; ifid_npc=4 and ifid_valid=1 one cycle after first hit.
REQ-028 BEQ redirect with id_zero=1, id_npc=0x40, id_imm=0xFFFE, ihit=1 -> next imemaddr=0x38, ifid_valid=0 for one cycle.
REQ-029 PCSRC_REG redirect, id_rdat=0x100, ihit=0 for 3 cycles then 1 -> imemaddr held 3 cycles, SQUASH entered, then imemaddr=0x100, squashed word never valid.
REQ-030 stall=1 for 2 cycles with ihit=1 and a BNE redirect present -> PC and ifid_* unchanged, no redirect taken.
REQ-031 halt=1 -> imemREN=0 and ifid_valid=0 next cycle, held indefinitely; RST -> imemaddr=0 and imemREN=1.
REQ-032 PC preloaded to 0xFFFFFFFC, ihit=1 -> ifid_npc=0x0, next imemaddr=0x0.
